// File: rtl/axis_sample_pacer_if.sv
// AXI-Stream beat bundle (tdata/tvalid/tready) shared by the pacer's input and output sides.
interface axis_sample_pacer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_sample_pacer.sv
// Rate-paced AXI-Stream sample source: FIFO-buffered upstream samples released one per
// sample period, with saturating counters for underruns and late ticks.
module axis_sample_pacer #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 100000,
  parameter int FIFO_DEPTH = 16,
  parameter int ZERO_FILL  = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  axis_sample_pacer_if.slave            s_axis,
  axis_sample_pacer_if.master           m_axis,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          underrun_count,
  output logic [CNT_WIDTH-1:0]          late_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         div_q, div_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  tready_q, tready_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [CNT_WIDTH-1:0]  und_q, und_d;
  logic [CNT_WIDTH-1:0]  late_q, late_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic push, pop, tick, und_inc, late_inc;

  assign push = s_axis.tvalid && tready_q;
  assign tick = enable && (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    state_d  = state_q;
    tdata_d  = tdata_q;
    pop      = 1'b0;
    und_inc  = 1'b0;
    late_inc = 1'b0;
    case (state_q)
      IDLE: if (enable) state_d = WAIT;
      WAIT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (tick) begin
          if (level_q != '0) begin
            pop     = 1'b1;
            tdata_d = mem_q[rd_ptr_q];
            state_d = SEND;
          end else begin
            und_inc = 1'b1;
            if (ZERO_FILL != 0) begin
              tdata_d = '0;
              state_d = SEND;
            end
          end
        end
      end
      SEND: begin
        // A tick during a pending beat is dropped, even on the handshake cycle.
        late_inc = tick;
        if (m_axis.tready) state_d = enable ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d    = enable ? ((div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + 1'b1) : '0;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // Registered ready derived from the next level so it is exact without a comb path.
    tready_d = (level_d != LW'(FIFO_DEPTH));
    und_d    = (und_inc && (und_q != '1)) ? und_q + 1'b1 : und_q;
    late_d   = (late_inc && (late_q != '1)) ? late_q + 1'b1 : late_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      tready_q <= 1'b0;
      tdata_q  <= '0;
      und_q    <= '0;
      late_q   <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      tready_q <= tready_d;
      tdata_q  <= tdata_d;
      und_q    <= und_d;
      late_q   <= late_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_axis.tdata;
  end

  assign s_axis.tready  = tready_q;
  assign m_axis.tvalid  = (state_q == SEND);
  assign m_axis.tdata   = tdata_q;
  assign fifo_level     = level_q;
  assign underrun_count = und_q;
  assign late_count     = late_q;
endmodule
